// File: rtl/fir_pkg.sv
// Shared types and default widths for the time-multiplexed FIR MAC sequencer.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } fir_state_e;

  localparam int DEF_WD_IN   = 24;
  localparam int DEF_WD_OUT  = 24;
  localparam int DEF_WD_COEF = 16;

  // Worst-case sum of NTAPS full-precision products fits without overflow.
  function automatic int acc_width(input int wd_in, input int wd_coef, input int ntaps);
    return wd_in + wd_coef + $clog2(ntaps);
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Circular sample buffer: write at wr_ptr, combinational read of the sample k steps older.
module fir_delay_line #(
  parameter int NTAPS = 16,
  parameter int WD_IN = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_we,
  input  logic [$clog2(NTAPS)-1:0] i_wr_ptr,
  input  logic [WD_IN-1:0]         i_wdata,
  input  logic [$clog2(NTAPS)-1:0] i_k,
  output logic [WD_IN-1:0]         o_rdata
);
  localparam int AW = $clog2(NTAPS);
  localparam logic [AW-1:0] NT_MOD = AW'(NTAPS);

  logic [WD_IN-1:0] r_mem [NTAPS];
  logic [AW-1:0]    w_idx;

  // Sample storage with synchronous clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_wr_ptr] <= i_wdata;
    end
  end

  // (wr_ptr - k) mod NTAPS; adding NTAPS on underflow also covers non-power-of-two depths
  always_comb begin
    w_idx = i_wr_ptr - i_k;
    if (i_wr_ptr < i_k) begin
      w_idx = i_wr_ptr - i_k + NT_MOD;
    end else begin
      w_idx = i_wr_ptr - i_k;
    end
  end

  assign o_rdata = r_mem[w_idx];

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one shared MAC walks NTAPS taps per accepted sample.
// Define FIR_SAT_EN to clamp the output to WD_OUT bits and expose sat_flag.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int WD_IN   = DEF_WD_IN,
  parameter int WD_OUT  = DEF_WD_OUT,
  parameter int WD_COEF = DEF_WD_COEF,
  parameter int NTAPS   = 16,
  parameter int FRAC    = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WD_IN-1:0]         data_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WD_OUT-1:0]        data_out,
  input  logic                     coef_we,
  input  logic [$clog2(NTAPS)-1:0] coef_addr,
  input  logic [WD_COEF-1:0]       coef_wdata,
  output logic                     busy
`ifdef FIR_SAT_EN
  ,
  output logic                     sat_flag
`endif
);
  localparam int AW    = $clog2(NTAPS);
  localparam int ACC_W = acc_width(WD_IN, WD_COEF, NTAPS);
  localparam int PW    = WD_IN + WD_COEF;
  localparam logic [AW-1:0] K_LAST  = AW'(NTAPS - 1);
  localparam logic [AW:0]   NTAPS_W = (AW + 1)'(NTAPS);

  fir_state_e               r_state;
  logic signed [ACC_W-1:0]  r_acc;
  logic [AW-1:0]            r_k;
  logic [AW-1:0]            r_wr_ptr;
  logic [WD_OUT-1:0]        r_data_out;
  logic                     r_out_valid;
  logic                     r_busy;
  logic [WD_COEF-1:0]       r_coef [NTAPS];

  logic                     w_accept;
  logic                     w_coef_wr;
  logic [WD_IN-1:0]         w_x;
  logic [WD_COEF-1:0]       w_c;
  logic signed [PW-1:0]     w_x_ext;
  logic signed [PW-1:0]     w_c_ext;
  logic signed [PW-1:0]     w_prod;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic [WD_OUT-1:0]        w_out;
  logic                     w_sat;

  assign w_accept  = in_valid && (r_state == IDLE);
  assign w_coef_wr = coef_we && (r_state == IDLE) && ({1'b0, coef_addr} < NTAPS_W);

  fir_delay_line #(
    .NTAPS (NTAPS),
    .WD_IN (WD_IN)
  ) u_delay_line (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (w_accept),
    .i_wr_ptr (r_wr_ptr),
    .i_wdata  (data_in),
    .i_k      (r_k),
    .o_rdata  (w_x)
  );

  // Operands sign-extended to full product width so the multiply is exact
  assign w_c        = r_coef[r_k];
  assign w_x_ext    = {{WD_COEF{w_x[WD_IN-1]}}, w_x};
  assign w_c_ext    = {{WD_IN{w_c[WD_COEF-1]}}, w_c};
  assign w_prod     = w_x_ext * w_c_ext;
  assign w_acc_next = r_acc + {{(ACC_W - PW){w_prod[PW-1]}}, w_prod};

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W - WD_OUT + 1){1'b0}}, {(WD_OUT - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W - WD_OUT + 1){1'b1}}, {(WD_OUT - 1){1'b0}}};
  logic signed [ACC_W-1:0] w_shift;
  logic                    r_sat_flag;

  assign w_shift = w_acc_next >>> FRAC;

  // Clamp the scaled accumulator into the signed output range
  always_comb begin
    w_out = w_shift[WD_OUT-1:0];
    w_sat = 1'b0;
    if (w_shift > SAT_MAX) begin
      w_out = WD_OUT'(SAT_MAX);
      w_sat = 1'b1;
    end else if (w_shift < SAT_MIN) begin
      w_out = WD_OUT'(SAT_MIN);
      w_sat = 1'b1;
    end else begin
      w_out = w_shift[WD_OUT-1:0];
      w_sat = 1'b0;
    end
  end

  assign sat_flag = r_sat_flag;
`else
  assign w_out = WD_OUT'(w_acc_next >>> FRAC);
  assign w_sat = 1'b0;
`endif

  // Sequencer FSM, MAC accumulator and coefficient file
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_k         <= '0;
      r_wr_ptr    <= '0;
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef FIR_SAT_EN
      r_sat_flag  <= 1'b0;
`endif
      for (int i = 0; i < NTAPS; i++) r_coef[i] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // The write lands before the sample's first MAC cycle reads it
          if (w_coef_wr) begin
            r_coef[coef_addr] <= coef_wdata;
          end
          if (w_accept) begin
            r_acc   <= '0;
            r_k     <= '0;
            r_busy  <= 1'b1;
            r_state <= MAC;
          end
        end
        MAC: begin
          r_acc <= w_acc_next;
          if (r_k == K_LAST) begin
            r_k         <= '0;
            r_data_out  <= w_out;
            r_out_valid <= 1'b1;
`ifdef FIR_SAT_EN
            r_sat_flag  <= w_sat;
`endif
            r_state     <= OUT;
          end else begin
            r_k <= r_k + AW'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef FIR_SAT_EN
            r_sat_flag  <= 1'b0;
`endif
            r_wr_ptr    <= (r_wr_ptr == K_LAST) ? '0 : r_wr_ptr + AW'(1);
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign data_out  = r_data_out;
  assign busy      = r_busy;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed scoreboard bench for fir_mac_sequencer (NTAPS=16, FRAC=0); FIR_SAT_EN adds clamp checks.
`timescale 1ns/1ps
module tb_fir_mac_sequencer;
  localparam int NT = 16;
  localparam int WI = 24;
  localparam int WO = 24;
  localparam int WC = 16;
  localparam int FR = 0;
  localparam int AW = $clog2(NT);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [WI-1:0] data_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [WO-1:0] data_out;
  logic          coef_we = 1'b0;
  logic [AW-1:0] coef_addr = '0;
  logic [WC-1:0] coef_wdata = '0;
  logic          busy;
`ifdef FIR_SAT_EN
  logic          sat_flag;
`endif

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int t_acc = 0;
  longint hist [NT];
  longint cf   [NT];
  logic [WO-1:0] exp_q [$];
  logic          exp_sat_q [$];

  fir_mac_sequencer #(
    .WD_IN(WI), .WD_OUT(WO), .WD_COEF(WC), .NTAPS(NT), .FRAC(FR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_in    (data_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .busy       (busy)
`ifdef FIR_SAT_EN
    ,
    .sat_flag   (sat_flag)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < NT; i++) begin
      hist[i] = 0;
      cf[i]   = 0;
    end
    exp_q.delete();
    exp_sat_q.delete();
  endfunction

  // Reference FIR: sum of newest-first history times coefficient, then scale
  function automatic void model_push();
    longint acc = 0;
    longint sh;
    logic   s = 1'b0;
    longint maxv = (longint'(1) << (WO - 1)) - 1;
    longint minv = -(longint'(1) << (WO - 1));
    for (int k = 0; k < NT; k++) acc += hist[k] * cf[k];
    sh = acc >>> FR;
`ifdef FIR_SAT_EN
    if (sh > maxv) begin
      sh = maxv;
      s  = 1'b1;
    end else if (sh < minv) begin
      sh = minv;
      s  = 1'b1;
    end
`else
    if (sh > maxv || sh < minv) s = 1'b0;
`endif
    exp_q.push_back(WO'(sh));
    exp_sat_q.push_back(s);
  endfunction

  task automatic do_reset(input string tag);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    coef_we  = 1'b0;
    tick();
    check({tag, "_rst_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_rst_data"},  64'(data_out),  64'd0);
    check({tag, "_rst_busy"},  64'(busy),      64'd0);
`ifdef FIR_SAT_EN
    check({tag, "_rst_sat"},   64'(sat_flag),  64'd0);
`endif
    rst_n = 1'b1;
    model_clear();
    check({tag, "_rst_ready"}, 64'(in_ready), 64'd1);
  endtask

  task automatic write_coef(input int k, input logic [WC-1:0] v);
    logic signed [WC-1:0] vs;
    coef_we    = 1'b1;
    coef_addr  = AW'(k);
    coef_wdata = v;
    tick();
    coef_we = 1'b0;
    vs = v;
    cf[k] = vs;
  endtask

  task automatic send(input logic [WI-1:0] x, input bit we = 1'b0, input int wa = 0,
                      input logic [WC-1:0] wv = '0);
    int n = 0;
    logic signed [WI-1:0] xs;
    logic signed [WC-1:0] ws;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check("in_ready_wait", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    data_in  = x;
    if (we) begin
      coef_we    = 1'b1;
      coef_addr  = AW'(wa);
      coef_wdata = wv;
      ws = wv;
      cf[wa] = ws;
    end
    tick();
    t_acc    = cyc;
    in_valid = 1'b0;
    coef_we  = 1'b0;
    for (int i = NT - 1; i > 0; i--) hist[i] = hist[i-1];
    xs = x;
    hist[0] = xs;
    model_push();
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_latency"}, 64'(cyc - t_acc), 64'(NT));
    check({tag, "_busy"}, 64'(busy), 64'd1);
    check({tag, "_sb_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
  endtask

  task automatic recv(input string tag);
    logic [WO-1:0] e;
    logic          es;
    out_ready = 1'b1;
    wait_valid(tag);
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      es = exp_sat_q.pop_front();
      check({tag, "_data"}, 64'(data_out), 64'(e));
`ifdef FIR_SAT_EN
      check({tag, "_sat"}, 64'(sat_flag), 64'(es));
`else
      if (es) check({tag, "_sat_model"}, 64'(es), 64'd0);
`endif
    end
    tick();
    check({tag, "_drop"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WO-1:0] hold;
    model_clear();

    // Reset state
    tick();
    do_reset("init");

    // Impulse response with coef[k] = k+1
    for (int k = 0; k < NT; k++) write_coef(k, WC'(k + 1));
    for (int n = 0; n <= NT; n++) begin
      send((n == 0) ? WI'(1) : WI'(0));
      recv($sformatf("imp%0d", n));
    end

    // DC step with unit coefficients, crossing the wr_ptr wrap
    for (int k = 0; k < NT; k++) write_coef(k, WC'(1));
    for (int n = 0; n < NT + 2; n++) begin
      send(WI'(100));
      recv($sformatf("dc%0d", n));
    end

    // Backpressure: OUT held for 10 cycles with in_valid asserted
    out_ready = 1'b0;
    send(WI'(5));
    wait_valid("bp");
    hold = exp_q[0];
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      data_in  = WI'(24'h123);
      tick();
      check($sformatf("bp_hold_data%0d", i),  64'(data_out),  64'(hold));
      check($sformatf("bp_hold_valid%0d", i), 64'(out_valid), 64'd1);
      check($sformatf("bp_in_ready%0d", i),   64'(in_ready),  64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    void'(exp_q.pop_front());
    void'(exp_sat_q.pop_front());
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_ready", 64'(in_ready),  64'd1);
    tick();
    check("bp_single_transfer", 64'(out_valid), 64'd0);
    send(WI'(0));
    recv("bp_after");

    // Coefficient write timing from a clean reset
    do_reset("cw");
    send(WI'(1), 1'b1, 0, WC'(7));
    for (int i = 0; i < 3; i++) begin
      coef_we    = 1'b1;
      coef_addr  = '0;
      coef_wdata = WC'(3);
      tick();
    end
    coef_we = 1'b0;
    recv("cw_idle_write");
    send(WI'(2));
    recv("cw_mac_dropped");

    // Reset while k == 5, then the impulse run must repeat exactly
    for (int k = 0; k < NT; k++) write_coef(k, WC'(k + 1));
    send(WI'(1));
    for (int i = 0; i < 5; i++) tick();
    check("mid_busy", 64'(busy), 64'd1);
    do_reset("mid");
    for (int i = 0; i < NT + 4; i++) tick();
    check("mid_no_output", 64'(out_valid), 64'd0);
    for (int k = 0; k < NT; k++) write_coef(k, WC'(k + 1));
    for (int n = 0; n <= NT; n++) begin
      send((n == 0) ? WI'(1) : WI'(0));
      recv($sformatf("imp2_%0d", n));
    end

`ifdef FIR_SAT_EN
    // Saturation at both ends of the output range
    do_reset("satp");
    for (int k = 0; k < NT; k++) write_coef(k, WC'(16'h7FFF));
    send(WI'(24'h7FFFFF));
    recv("sat_pos");
    check("sat_pos_value", 64'(data_out), 64'h7FFFFF);
    do_reset("satn");
    for (int k = 0; k < NT; k++) write_coef(k, WC'(16'h7FFF));
    send(WI'(24'h800000));
    recv("sat_neg");
    check("sat_neg_value", 64'(data_out), 64'h800000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
